// File: rtl/pio_pkg.sv
// Shared constants for the pio_gen_edge_irq GPIO slave: register addresses,
// edge-type encodings and the edge-event helper.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Edge event from the current conditioned level and its one-cycle-old copy.
  function automatic logic edge_event(input int edge_type, input logic lvl, input logic lvl_d);
    case (edge_type)
      EDGE_RISE: edge_event = lvl & ~lvl_d;
      EDGE_FALL: edge_event = ~lvl & lvl_d;
      default:   edge_event = lvl ^ lvl_d;
    endcase
  endfunction

endpackage

// File: rtl/pio_bit_conditioner.sv
// Per-pin input path: synchroniser, optional debounce filter (PIO_DEBOUNCE_EN)
// and the delayed-level flop used to detect edges.
module pio_bit_conditioner
  import pio_pkg::*;
#(
  parameter int EDGE_TYPE       = EDGE_RISE,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic edge_evt
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535)
  begin : g_bad_param
    $error("pio_bit_conditioner: SYNC_STAGES or DEBOUNCE_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   filt;
  logic                   level_d_q;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        filt_q, filt_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = s;
      else                   cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_d_q <= 1'b0;
    else          level_d_q <= filt;
  end

  assign level    = filt;
  assign edge_evt = edge_event(EDGE_TYPE, filt, level_d_q);

endmodule

// File: rtl/pio_gen_edge_irq.sv
// Avalon-MM GPIO slave: DATA/DIR/IRQMASK/EDGECAP registers, sticky edge
// capture and level IRQ. Input debounce is built when PIO_DEBOUNCE_EN is defined.
module pio_gen_edge_irq
  import pio_pkg::*;
#(
  parameter int          WIDTH           = 8,
  parameter int          EDGE_TYPE       = EDGE_RISE,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [31:0] RESET_OUT       = 32'd0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_param
    $error("pio_gen_edge_irq: WIDTH or EDGE_TYPE out of range");
  end

  localparam logic [WIDTH-1:0] OUT_RST = RESET_OUT[WIDTH-1:0];

  logic [WIDTH-1:0] level, evt;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_bit_conditioner #(
      .EDGE_TYPE      (EDGE_TYPE),
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .level   (level[i]),
      .edge_evt(evt[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    out_d  = writedata[WIDTH-1:0];
        ADDR_DIR:     dir_d  = writedata[WIDTH-1:0];
        ADDR_IRQMASK: mask_d = writedata[WIDTH-1:0];
        default:      clr    = writedata[WIDTH-1:0];
      endcase
    end
    // A new event outranks a same-cycle write-1-clear of that bit.
    edgecap_d = (edgecap_q & ~clr) | evt;

    case (address)
      ADDR_DATA:    rdata_d = 32'(level);
      ADDR_DIR:     rdata_d = 32'(dir_q);
      ADDR_IRQMASK: rdata_d = 32'(mask_q);
      default:      rdata_d = 32'(edgecap_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= OUT_RST;
      dir_q     <= '0;
      mask_q    <= '0;
      edgecap_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
      rdata_q   <= rdata_d;
      irq_q     <= |(edgecap_q & mask_q);
    end
  end

  assign out_port = out_q;
  assign out_en   = dir_q;
  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_gen_edge_irq.sv
// Self-checking bench for pio_gen_edge_irq: directed register/capture/IRQ
// scenarios plus randomized traffic against a behavioural model.
module tb_pio_gen_edge_irq;

  localparam int          W       = 8;
  localparam int          ET      = 0;
  localparam int          SS      = 2;
  localparam int          DEB     = 4;
  localparam logic [31:0] RST_OUT = 32'h0000_00A5;
`ifdef PIO_DEBOUNCE_EN
  localparam int LAT = SS + 1 + DEB;
`else
  localparam int LAT = SS + 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic [W-1:0]  out_port;
  logic [W-1:0]  out_en;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [W-1:0] hist [SS+2];  // hist[k]: in_port sampled k edges before the coming one
  logic [W-1:0] m_out, m_dir, m_mask, m_ec, m_f, m_fd;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           run [W];

  pio_gen_edge_irq #(
    .WIDTH(W), .EDGE_TYPE(ET), .SYNC_STAGES(SS), .RESET_OUT(RST_OUT), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_en(out_en), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int k = 0; k < SS + 2; k++) hist[k] = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
    m_out = RST_OUT[W-1:0];
    m_dir = '0; m_mask = '0; m_ec = '0; m_f = '0; m_fd = '0;
    m_rd = '0; m_irq = 1'b0;
  endtask

  // One clock cycle: compute model next state from pre-edge state and inputs.
  task automatic tick();
    logic [W-1:0] s, sd, ev, clr, nf;
    logic [31:0]  rd_n;
    logic         irq_n, wr;
    hist[0] = in_port;
`ifdef PIO_DEBOUNCE_EN
    s = m_f; sd = m_fd;
`else
    s = hist[SS]; sd = hist[SS+1];
`endif
    case (ET)
      0:       ev = s & ~sd;
      1:       ev = ~s & sd;
      default: ev = s ^ sd;
    endcase
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    case (address)
      2'd0:    rd_n = 32'(s);
      2'd1:    rd_n = 32'(m_dir);
      2'd2:    rd_n = 32'(m_mask);
      default: rd_n = 32'(m_ec);
    endcase
    irq_n = |(m_ec & m_mask);
    nf = m_f;
    for (int i = 0; i < W; i++) begin
      if (hist[SS][i] != m_f[i]) begin
        run[i]++;
        if (run[i] == DEB) begin nf[i] = hist[SS][i]; run[i] = 0; end
      end else run[i] = 0;
    end
    @(posedge clk);
    m_ec = (m_ec & ~clr) | ev;
    if (wr && address == 2'd0) m_out  = writedata[W-1:0];
    if (wr && address == 2'd1) m_dir  = writedata[W-1:0];
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    m_rd = rd_n; m_irq = irq_n;
    m_fd = m_f; m_f = nf;
    for (int k = SS + 1; k > 0; k--) hist[k] = hist[k-1];
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_checks++;
    if (out_port !== 8'hA5 || out_en !== 8'h00 || irq !== 1'b0 || readdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: out_port=%h out_en=%h irq=%b readdata=%h, want a5 00 0 0",
               out_port, out_en, irq, readdata);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int a = 1; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_read addr%0d: got %h want 00000000", a, rd);
      end
    end
    bus_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h0 || out_port !== 8'hA5) begin
      n_errors++;
      $display("FAIL reset_data: readdata=%h out_port=%h want 0 a5", rd, out_port);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    bus_write(2'd0, 32'hFFFF_FF3C);
    bus_write(2'd1, 32'h0000_000F);
    n_checks++;
    if (out_port !== 8'h3C || out_en !== 8'h0F) begin
      n_errors++;
      $display("FAIL write_outputs: out_port=%h out_en=%h want 3c 0f", out_port, out_en);
    end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h0000_000F) begin
      n_errors++;
      $display("FAIL dir_readback: got %h want 0000000f", rd);
    end
  endtask

  task automatic test_rising_capture();
    logic [31:0] rd;
    in_port = 8'h81;
    repeat (LAT - 1) tick();
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL capture_early: got %h want 00000000", rd);
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h81) begin
      n_errors++;
      $display("FAIL capture_latency: got %h want 00000081", rd);
    end
    in_port = 8'h00;
    repeat (LAT + 2) tick();
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h81) begin
      n_errors++;
      $display("FAIL capture_fall_ignored: got %h want 00000081", rd);
    end
    bus_write(2'd3, 32'h0000_0001);
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h80) begin
      n_errors++;
      $display("FAIL capture_clear: got %h want 00000080", rd);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    bus_write(2'd2, 32'h80);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_mask_early: got %b want 0", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_assert: got %b want 1", irq); end
    bus_write(2'd3, 32'h80);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_hold_on_clear: got %b want 1", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_deassert: got %b want 0", irq); end
    bus_write(2'd2, 32'h0);
    in_port = 8'h80;
    repeat (LAT + 2) tick();
    bus_read(2'd3, rd);
    n_checks++;
    if (irq !== 1'b0 || rd !== 32'h80) begin
      n_errors++;
      $display("FAIL irq_masked: irq=%b edgecap=%h want 0 00000080", irq, rd);
    end
    in_port = 8'h00;
    repeat (LAT + 1) tick();
    bus_write(2'd3, 32'hFF);
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    in_port = 8'h04;
    repeat (LAT + 1) tick();
    in_port = 8'h00;
    repeat (LAT + 2) tick();
    in_port = 8'h04;
    repeat (LAT - 1) tick();
    bus_write(2'd3, 32'h04);  // clear lands on the same edge as the new capture
    bus_read(2'd3, rd);
    n_checks++;
    if (rd[2] !== 1'b1 || rd !== m_rd) begin
      n_errors++;
      $display("FAIL collision: edgecap=%h want bit2 set, model %h", rd, m_rd);
    end
    in_port = 8'h00;
    repeat (LAT + 1) tick();
  endtask

`ifdef PIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] rd, rc;
    bus_write(2'd3, 32'hFF);
    in_port = 8'h01;
    repeat (3) tick();
    in_port = 8'h00;
    repeat (LAT + 4) tick();
    bus_read(2'd0, rd);
    bus_read(2'd3, rc);
    n_checks++;
    if (rd[0] !== 1'b0 || rc[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL debounce_glitch: data=%h edgecap=%h want bit0 0/0", rd, rc);
    end
    in_port = 8'h01;
    repeat (10) tick();
    bus_read(2'd0, rd);
    bus_read(2'd3, rc);
    n_checks++;
    if (rd[0] !== 1'b1 || rc[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL debounce_stable: data=%h edgecap=%h want bit0 1/1", rd, rc);
    end
    in_port = 8'h00;
    repeat (LAT + 2) tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address    = 2'($urandom);
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      tick();
      n_checks++;
      if (readdata !== m_rd || out_port !== m_out || out_en !== m_dir || irq !== m_irq) begin
        n_errors++;
        $display("FAIL random cycle%0d: rd=%h out=%h en=%h irq=%b want %h %h %h %b",
                 c, readdata, out_port, out_en, irq, m_rd, m_out, m_dir, m_irq);
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    bus_write(2'd2, 32'hFF);
    bus_write(2'd0, 32'h5A);
    for (int c = 0; c < 20; c++) begin in_port = W'($urandom); tick(); end
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_port !== 8'hA5 || out_en !== 8'h00 || irq !== 1'b0 || readdata !== 32'h0) begin
      n_errors++;
      $display("FAIL midop_reset: out_port=%h out_en=%h irq=%b readdata=%h want a5 00 0 0",
               out_port, out_en, irq, readdata);
    end
    in_port = '0;
    model_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h0 || rd !== m_rd) begin
      n_errors++;
      $display("FAIL midop_edgecap: got %h want 00000000", rd);
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL midop_mask: got %h want 00000000", rd);
    end
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_rising_capture();
    test_irq();
    test_collision();
`ifdef PIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_gen_edge_irq.md
Name: pio_gen_edge_irq

Overview:
- Parametrised Avalon-MM PIO slave, successor to the single-bit read-only ID port.
- Provides WIDTH-bit bidirectional GPIO: input synchroniser, per-bit direction, output register, edge capture with programmable edge type, per-bit interrupt mask and a level IRQ.
- Sits on the Qsys/Nios II system interconnect next to the sensor and LCD control PIOs.

Parameters:
- WIDTH, 8: number of GPIO bits, 1..32.
- EDGE_TYPE, 0: capture edge. 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- RESET_OUT, 0: reset value of the output data register (WIDTH bits, zero-extended).
- DEBOUNCE_CYCLES, 16: stable-cycle count. Used only when PIO_DEBOUNCE_EN is defined. Range 2..65535.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: reset. Asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- address, input, 2: register select.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe, qualified by chipselect.
- writedata, input, 32: write data.
- readdata, output, 32: registered read data.
- in_port, input, WIDTH: raw asynchronous pin inputs.
- out_port, output, WIDTH: output data register.
- out_en, output, WIDTH: per-bit output enable (1 = drive). The tristate buffer lives at top level.
- irq, output, 1: level interrupt, active-high.

Behaviour:
- Register map, word addresses:
  - 0 DATA: read returns the synchronised (or debounced) inputs; write loads out_port.
  - 1 DIR: read/write out_en.
  - 2 IRQMASK: read/write mask.
  - 3 EDGECAP: read returns captured edges; write 1 to a bit clears it, write 0 has no effect.
- Bits [31:WIDTH] read as 0. Writes to those bits are ignored.
- Write occurs on a rising clk when chipselect=1 and write_n=0. The written value is visible on out_port/out_en the next cycle.
- readdata <= mux(address) every cycle, with no read strobe. One-cycle latency from address to readdata.
- Synchroniser: SYNC_STAGES flops per bit. The last stage is s; a further flop holds s_d for edge detect.
- Edge event per bit:
  - rising: s & ~s_d
  - falling: ~s & s_d
  - any: s ^ s_d
- EDGECAP[i] sets on an event and holds until cleared.
- Simultaneous event and write-1-clear on the same bit in the same cycle: the set wins, so the bit stays 1.
- Edge detection is independent of DIR. Output-configured bits still capture if the pin is looped back.
- irq is a registered |(EDGECAP & IRQMASK). It asserts one cycle after the capture bit sets and deasserts one cycle after the clear or mask.
- Reset values:
  - readdata = 0, out_port = RESET_OUT, out_en = 0, IRQMASK = 0, EDGECAP = 0, irq = 0.
  - Synchroniser flops and s_d = 0.
- After reset release, the first synchronised 1 on any bit counts as a rising edge. Software clears EDGECAP before unmasking.
- Reset mid-operation clears all state immediately, including pending captures. No partial writes.
- Latency from a pin transition to EDGECAP set: SYNC_STAGES+1 cycles.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- Defined: each bit gets a 16-bit stable counter after the synchroniser.
  - The filtered value f updates to s only after s has differed from f for DEBOUNCE_CYCLES consecutive cycles.
  - A glitch shorter than that resets the counter and produces no f change.
  - DATA reads and edge detection use f. Added latency is DEBOUNCE_CYCLES cycles. The counter resets to 0 and f to 0.
- Undefined: no counter is built, f = s, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - edge encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module pio_bit_conditioner, instantiated WIDTH times in a generate loop. It contains the synchroniser, the optional debounce counter and the s_d flop, and outputs the filtered level and edge event.
- Register file, capture logic and read mux stay in the top module.

Test Plan:
- Reset/readback (WIDTH=8, RESET_OUT=8'hA5): release reset, read addr 0..3 → out_port=8'hA5, out_en=0, irq=0, readdata of DIR/IRQMASK/EDGECAP = 0.
- Write/read (WIDTH=8): write DATA=32'hFFFF_FF3C, DIR=32'h0F → out_port=8'h3C, out_en=8'h0F next cycle; DIR reads back 32'h0000_000F.
- Rising capture (EDGE_TYPE=0): in_port 8'h00→8'h81 → EDGECAP=8'h81 after SYNC_STAGES+1 cycles; in_port→8'h00 gives no change; write EDGECAP=8'h01 → reads 8'h80.
- IRQ: IRQMASK=8'h80 with EDGECAP=8'h80 → irq=1 next cycle; write EDGECAP=8'h80 → irq=0 one cycle after the clear takes effect; IRQMASK=0 with an edge on bit 7 → irq stays 0.
- Collision: rising edge on bit 2 in the same cycle as a write-1-clear of EDGECAP bit 2 → bit 2 reads 1 afterwards.
- Debounce (PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4): 3-cycle high pulse on bit 0 → DATA bit 0 stays 0, no capture; 10-cycle high → DATA bit 0=1 and EDGECAP bit 0=1.
